fma_result_checker: RTL

Self-checking consumer for the 32×32+64 fused multiply-add datapath. It accepts one operand set (a, b, c) per transaction and computes the expected result `a*b+c mod 2^64` with an iterative shift-add engine. It samples the FMA output a fixed number of cycles after the operands were presented, then reports pass or fail and keeps pass/fail counts. It sits at the output end of the FMA pipeline, opposite the stimulus driver, and is synthesizable for on-board self-test.

---
 rtl/fma_result_checker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fma_result_checker.sv
// Checks a 32x32+64 FMA datapath against an iterative shift-add reference and keeps pass/fail statistics.
// Define FMA_CHK_ERRLOG_EN to build the first-failure log (err_*); otherwise err_* are tied to 0.
//   state | meaning
//   IDLE  | waiting for an operand set
//   RUN   | shift-add multiply, waiting for the dut_out sample point
//   CMP   | compare, publish verdict, update counters (can accept the next set)
module fma_result_checker #(
    parameter int DUT_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [63:0]      c,
    input  logic [63:0]      dut_out,
    input  logic             clr_cnt,
    output logic             done,
    output logic             pass,
    output logic [63:0]      expected,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             any_fail,
    output logic [31:0]      err_a,
    output logic [31:0]      err_b,
    output logic [63:0]      err_c,
    output logic [63:0]      err_got
);
    typedef enum logic [1:0] {IDLE, RUN, CMP} state_t;

    localparam logic [7:0]       LAT_LAST = 8'(DUT_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t      state;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  bit_cnt;
    logic        mul_done;
    logic [7:0]  lat_cnt;
    logic        captured;
    logic [63:0] got;

    logic accept;
    logic mul_fin;
    logic cap_now;
    logic match;

    // in_ready is registered and is high in IDLE and CMP, so acceptance is just the handshake
    assign accept  = in_valid && in_ready;
    assign mul_fin = mul_done || (bit_cnt == 5'd31);
    assign cap_now = !captured && (lat_cnt == LAT_LAST);
    assign match   = (got == acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            bit_cnt  <= '0;
            mul_done <= 1'b0;
            lat_cnt  <= '0;
            captured <= 1'b0;
            got      <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            expected <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            any_fail <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: ;
                RUN: begin
                    if (!mul_done) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) mul_done <= 1'b1;
                    end
                    if (!captured) lat_cnt <= lat_cnt + 8'd1;
                    if (cap_now) begin
                        got      <= dut_out;
                        captured <= 1'b1;
                    end
                    if (mul_fin && (captured || cap_now)) begin
                        state    <= CMP;
                        in_ready <= 1'b1;
                    end
                end
                CMP: begin
                    done     <= 1'b1;
                    pass     <= match;
                    expected <= acc;
                    state    <= IDLE;
                    if (match) begin
                        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
                        any_fail <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // a new operand set may arrive while CMP publishes the previous verdict
            if (accept) begin
                state    <= RUN;
                in_ready <= 1'b0;
                acc      <= c;
                mcand    <= {32'd0, a};
                mplier   <= b;
                bit_cnt  <= '0;
                mul_done <= 1'b0;
                lat_cnt  <= '0;
                captured <= 1'b0;
            end
            if (clr_cnt) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
                any_fail <= 1'b0;
            end
        end
    end

`ifdef FMA_CHK_ERRLOG_EN
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] op_c;

    // any_fail low means the log is still empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a    <= '0;
            op_b    <= '0;
            op_c    <= '0;
            err_a   <= '0;
            err_b   <= '0;
            err_c   <= '0;
            err_got <= '0;
        end else begin
            if (accept) begin
                op_a <= a;
                op_b <= b;
                op_c <= c;
            end
            if (clr_cnt) begin
                err_a   <= '0;
                err_b   <= '0;
                err_c   <= '0;
                err_got <= '0;
            end else if ((state == CMP) && !match && !any_fail) begin
                err_a   <= op_a;
                err_b   <= op_b;
                err_c   <= op_c;
                err_got <= got;
            end
        end
    end
`else
    assign err_a   = '0;
    assign err_b   = '0;
    assign err_c   = '0;
    assign err_got = '0;
`endif

endmodule
